seg7_cmd_display: RTL and testbench



---
 rtl/seg7_cmd_display.sv | 164 ++++++++++++++++
 tb/tb_seg7_cmd_display.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_cmd_display.sv
// Command parser for the UART byte stream and a multiplexed 7-segment driver.
// Frames are staged in a shadow image and committed to the display atomically.
module seg7_cmd_display #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 100000,
  parameter int TIMEOUT      = 1000000,
  parameter int COMMON_ANODE = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_byte,
  input  logic                  rbyte_ready,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] dig,
  output logic                  frame_ok,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [IW-1:0] LAST      = IW'(NUM_DIGITS - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic          INV       = (COMMON_ANODE != 0);

  localparam logic [7:0] CMD_S = 8'h53;
  localparam logic [7:0] CMD_C = 8'h43;

  typedef enum logic {IDLE, DATA} state_t;

  // Returns {valid, dp, gfedcba}.
  function automatic logic [8:0] decode(input logic [7:0] b);
    logic [6:0] g;
    logic       ok;
    g  = 7'h00;
    ok = 1'b1;
    case (b[6:0])
      7'h30: g = 7'h3F;
      7'h31: g = 7'h06;
      7'h32: g = 7'h5B;
      7'h33: g = 7'h4F;
      7'h34: g = 7'h66;
      7'h35: g = 7'h6D;
      7'h36: g = 7'h7D;
      7'h37: g = 7'h07;
      7'h38: g = 7'h7F;
      7'h39: g = 7'h6F;
      7'h41, 7'h61: g = 7'h77;
      7'h42, 7'h62: g = 7'h7C;
      7'h43, 7'h63: g = 7'h39;
      7'h44, 7'h64: g = 7'h5E;
      7'h45, 7'h65: g = 7'h79;
      7'h46, 7'h66: g = 7'h71;
      7'h2D: g = 7'h40;
      7'h20: g = 7'h00;
      default: ok = 1'b0;
    endcase
    return {ok, b[7], g};
  endfunction

  state_t          state;
  logic [IW-1:0]   idx;
  logic [TW-1:0]   tcnt;
  logic [7:0]      shadow  [NUM_DIGITS];
  logic [7:0]      display [NUM_DIGITS];
  logic [SW-1:0]   scnt;
  logic [IW-1:0]   sidx;
  logic [8:0]      dec;
  logic            dvalid;
  logic [7:0]      glyph;
  logic [NUM_DIGITS-1:0] sel;

  assign dec    = decode(rx_byte);
  assign dvalid = dec[8];
  assign glyph  = dec[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      tcnt      <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow[i]  <= 8'h00;
        display[i] <= 8'h00;
      end
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rbyte_ready) begin
            if (rx_byte == CMD_S) begin
              state <= DATA;
              busy  <= 1'b1;
              idx   <= '0;
              tcnt  <= '0;
            end else if (rx_byte == CMD_C) begin
              for (int i = 0; i < NUM_DIGITS; i++)
                display[i] <= 8'h00;
              frame_ok <= 1'b1;
            end
          end
        end
        DATA: begin
          if (rbyte_ready) begin
            if (!dvalid) begin
              state     <= IDLE;
              busy      <= 1'b0;
              frame_err <= 1'b1;
            end else begin
              shadow[idx] <= glyph;
              tcnt        <= '0;
              idx         <= idx + 1'b1;
              if (idx == LAST) begin
                // Final byte bypasses the shadow so the commit is one edge.
                for (int i = 0; i < NUM_DIGITS; i++)
                  display[i] <= shadow[i];
                display[NUM_DIGITS-1] <= glyph;
                idx      <= '0;
                state    <= IDLE;
                busy     <= 1'b0;
                frame_ok <= 1'b1;
              end
            end
          end else if (tcnt == TO_LAST) begin
            state     <= IDLE;
            busy      <= 1'b0;
            frame_err <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sel = NUM_DIGITS'(1) << (LAST - sidx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt <= '0;
      sidx <= '0;
      seg  <= {8{INV}};
      dig  <= {NUM_DIGITS{INV}};
    end else begin
      if (scnt == SCAN_LAST) begin
        scnt <= '0;
        sidx <= (sidx == LAST) ? '0 : sidx + 1'b1;
      end else begin
        scnt <= scnt + 1'b1;
      end
      seg <= display[sidx] ^ {8{INV}};
      dig <= sel ^ {NUM_DIGITS{INV}};
    end
  end

endmodule

// File: tb/tb_seg7_cmd_display.sv
// Randomized and directed bench for seg7_cmd_display.
// Two instances (common cathode/anode) share the same byte stream.
module tb_seg7_cmd_display;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int TO = 50;

  localparam logic [6:0] HEX7 [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          rbyte_ready = 1'b0;
  logic [7:0]    seg, seg_ca;
  logic [ND-1:0] dig, dig_ca;
  logic          frame_ok, frame_err, busy;
  logic          ok_ca, err_ca, busy_ca;

  seg7_cmd_display #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .TIMEOUT(TO), .COMMON_ANODE(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rbyte_ready(rbyte_ready),
    .seg(seg), .dig(dig), .frame_ok(frame_ok), .frame_err(frame_err),
    .busy(busy)
  );

  seg7_cmd_display #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .TIMEOUT(TO), .COMMON_ANODE(1)
  ) dut_ca (
    .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rbyte_ready(rbyte_ready),
    .seg(seg_ca), .dig(dig_ca), .frame_ok(ok_ca), .frame_err(err_ca),
    .busy(busy_ca)
  );

  always #5 clk = ~clk;

  // Clock edges seen since reset release: drives the expected scan slot.
  int cyc;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  int total  = 0;
  int passed = 0;

  logic [7:0] mdisp   [ND];
  logic [7:0] mshadow [ND];
  bit         mframe;
  int         midx;
  int         midle;

  function automatic logic [8:0] ref_glyph(input logic [7:0] b);
    int v;
    v = int'(b[6:0]);
    if (v >= 48 && v <= 57)       return {1'b1, b[7], HEX7[v-48]};
    else if (v >= 65 && v <= 70)  return {1'b1, b[7], HEX7[v-55]};
    else if (v >= 97 && v <= 102) return {1'b1, b[7], HEX7[v-87]};
    else if (v == 45)             return {1'b1, b[7], 7'h40};
    else if (v == 32)             return {1'b1, b[7], 7'h00};
    return 9'h000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ND; i++) begin
      mdisp[i]   = 8'h00;
      mshadow[i] = 8'h00;
    end
    mframe = 0;
    midx   = 0;
    midle  = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, output logic eok,
                            output logic eerr);
    logic [8:0] g;
    eok  = 1'b0;
    eerr = 1'b0;
    if (!mframe) begin
      if (b == 8'h53) begin
        mframe = 1;
        midx   = 0;
        midle  = 0;
      end else if (b == 8'h43) begin
        for (int i = 0; i < ND; i++) mdisp[i] = 8'h00;
        eok = 1'b1;
      end
    end else begin
      g = ref_glyph(b);
      if (!g[8]) begin
        eerr   = 1'b1;
        mframe = 0;
      end else begin
        mshadow[midx] = g[7:0];
        midx++;
        midle = 0;
        if (midx == ND) begin
          for (int i = 0; i < ND; i++) mdisp[i] = mshadow[i];
          eok    = 1'b1;
          mframe = 0;
        end
      end
    end
  endtask

  task automatic model_idle(output logic eerr);
    eerr = 1'b0;
    if (mframe) begin
      midle++;
      if (midle >= TO) begin
        eerr   = 1'b1;
        mframe = 0;
      end
    end
  endtask

  task automatic send(input logic [7:0] b, output logic ok, output logic err,
                      output logic eok, output logic eerr);
    rx_byte     = b;
    rbyte_ready = 1'b1;
    @(negedge clk);
    rbyte_ready = 1'b0;
    ok  = frame_ok;
    err = frame_err;
    model_byte(b, eok, eerr);
  endtask

  task automatic idle1(output logic ok, output logic err, output logic eerr);
    @(negedge clk);
    ok  = frame_ok;
    err = frame_err;
    model_idle(eerr);
  endtask

  // Bytes are packed with the first byte in the most significant slot.
  task automatic send_frame(input string name, input int n,
                            input logic [8*12-1:0] bytes);
    logic ok, err, eok, eerr;
    for (int i = 0; i < n; i++) begin
      send(bytes[8*(n-1-i) +: 8], ok, err, eok, eerr);
      total++;
      if ({ok, err} !== {eok, eerr})
        $display("FAIL %s_pulse byte%0d ok/err got %b%b want %b%b",
                 name, i, ok, err, eok, eerr);
      else passed++;
      total++;
      if (busy !== mframe)
        $display("FAIL %s_busy byte%0d got %b want %b", name, i, busy, mframe);
      else passed++;
    end
  endtask

  task automatic scan_check(input string name, input int n);
    logic ok, err, eerr;
    int   k;
    logic [ND-1:0] ed;
    logic [7:0]    es;
    for (int i = 0; i < n; i++) begin
      idle1(ok, err, eerr);
      k  = ((cyc - 1) / SD) % ND;
      ed = ND'(1) << (ND - 1 - k);
      es = mdisp[k];
      total++;
      if (dig !== ed) $display("FAIL %s_dig got %b want %b", name, dig, ed);
      else passed++;
      total++;
      if (seg !== es) $display("FAIL %s_seg got %h want %h", name, seg, es);
      else passed++;
      total++;
      if ({seg_ca, dig_ca} !== ~{es, ed})
        $display("FAIL %s_ca got %h/%b want %h/%b", name, seg_ca, dig_ca,
                 ~es, ~ed);
      else passed++;
      total++;
      if ({ok, err} !== {1'b0, eerr})
        $display("FAIL %s_pulse ok/err got %b%b want 0%b", name, ok, err, eerr);
      else passed++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({seg, dig} !== 12'h000)
      $display("FAIL reset_out got %h/%b want 00/0000", seg, dig);
    else passed++;
    total++;
    if ({seg_ca, dig_ca} !== 12'hFFF)
      $display("FAIL reset_ca got %h/%b want ff/1111", seg_ca, dig_ca);
    else passed++;
    total++;
    if ({frame_ok, frame_err, busy} !== 3'b000)
      $display("FAIL reset_flags got %b want 000", {frame_ok, frame_err, busy});
    else passed++;
    model_reset();
    rst_n = 1'b1;
    scan_check("reset_scan", 16);
  endtask

  task automatic test_basic();
    send_frame("basic", 5, {8'h53, 8'h31, 8'h32, 8'hB3, 8'h34});
    total++;
    if (frame_ok !== 1'b1) $display("FAIL basic_ok got %b want 1", frame_ok);
    else passed++;
    scan_check("basic_scan", 20);
  endtask

  task automatic test_invalid();
    send_frame("inval", 3, {8'h53, 8'h31, 8'h47});
    total++;
    if ({frame_err, busy} !== 2'b10)
      $display("FAIL inval_err err/busy got %b want 10", {frame_err, busy});
    else passed++;
    scan_check("inval_hold", 16);
    send_frame("dash", 5, {8'h53, 8'h2D, 8'h2D, 8'h2D, 8'h2D});
    scan_check("dash_scan", 16);
  endtask

  task automatic test_timeout();
    logic ok, err, eerr;
    int   nerr;
    send_frame("to", 3, {8'h53, 8'h38, 8'h38});
    nerr = 0;
    for (int i = 0; i < TO + 5; i++) begin
      idle1(ok, err, eerr);
      if (err) nerr++;
      total++;
      if ({ok, err} !== {1'b0, eerr})
        $display("FAIL to_idle%0d ok/err got %b%b want 0%b", i, ok, err, eerr);
      else passed++;
    end
    total++;
    if (nerr !== 1) $display("FAIL to_count got %0d want 1", nerr);
    else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL to_busy got %b want 0", busy);
    else passed++;
    scan_check("to_hold", 16);
    send_frame("edge", 3, {8'h53, 8'h38, 8'h38});
    for (int i = 0; i < TO - 1; i++) begin
      idle1(ok, err, eerr);
      total++;
      if ({ok, err, busy} !== {1'b0, eerr, mframe})
        $display("FAIL edge_idle%0d got %b%b%b want 0%b%b", i, ok, err, busy,
                 eerr, mframe);
      else passed++;
    end
    send_frame("edge_end", 2, {8'h38, 8'h38});
    total++;
    if (frame_ok !== 1'b1) $display("FAIL edge_ok got %b want 1", frame_ok);
    else passed++;
    scan_check("edge_scan", 16);
  endtask

  task automatic test_resync();
    send_frame("resync", 7,
               {8'h41, 8'h7F, 8'h53, 8'h61, 8'h62, 8'h63, 8'h64});
    scan_check("resync_scan", 16);
  endtask

  task automatic test_clear();
    send_frame("clear", 1, {8'h43});
    total++;
    if (frame_ok !== 1'b1) $display("FAIL clear_ok got %b want 1", frame_ok);
    else passed++;
    scan_check("clear_scan", 16);
  endtask

  task automatic test_back_to_back();
    send_frame("b2b", 11, {8'h53, 8'h30, 8'h31, 8'h32, 8'h33,
                           8'h53, 8'hB4, 8'h45, 8'h66, 8'h20, 8'h43});
    scan_check("b2b_scan", 16);
    send_frame("b2b2", 5, {8'h53, 8'h39, 8'h38, 8'h37, 8'hB6});
    scan_check("b2b2_scan", 16);
  endtask

  task automatic test_reset_midframe();
    send_frame("mid", 3, {8'h53, 8'h31, 8'h32});
    rst_n = 1'b0;
    #1;
    model_reset();
    total++;
    if ({seg, dig, busy, frame_ok, frame_err} !== 15'h0)
      $display("FAIL mid_reset got %h/%b/%b%b%b want 00/0000/000", seg, dig,
               busy, frame_ok, frame_err);
    else passed++;
    repeat (2) @(negedge clk);
    total++;
    if ({seg_ca, dig_ca, busy, frame_ok, frame_err} !== 15'h7FF8)
      $display("FAIL mid_hold got %h/%b/%b%b%b want ff/1111/000", seg_ca,
               dig_ca, busy, frame_ok, frame_err);
    else passed++;
    rst_n = 1'b1;
    scan_check("mid_blank", 8);
    send_frame("mid_new", 5, {8'h53, 8'h37, 8'hB8, 8'h2D, 8'h46});
    scan_check("mid_scan", 16);
  endtask

  task automatic test_random();
    string chars = " -0123456789ABCDEFabcdef";
    logic [7:0] b;
    logic ok, err, eok, eerr;
    int r, g;
    for (int it = 0; it < 250; it++) begin
      r = $urandom_range(0, 99);
      if (r < 15)      b = 8'h53;
      else if (r < 20) b = 8'h43;
      else if (r < 90) b = {1'($urandom_range(0, 1)),
                            chars[$urandom_range(0, chars.len() - 1)][6:0]};
      else             b = 8'($urandom_range(0, 255));
      send(b, ok, err, eok, eerr);
      total++;
      if ({ok, err, busy} !== {eok, eerr, mframe})
        $display("FAIL rnd_byte%0d %h got %b%b%b want %b%b%b", it, b, ok, err,
                 busy, eok, eerr, mframe);
      else passed++;
      g = ($urandom_range(0, 19) == 0) ? $urandom_range(45, 55)
                                      : $urandom_range(0, 3);
      for (int j = 0; j < g; j++) begin
        idle1(ok, err, eerr);
        total++;
        if ({ok, err, busy} !== {1'b0, eerr, mframe})
          $display("FAIL rnd_gap%0d got %b%b%b want 0%b%b", it, ok, err, busy,
                   eerr, mframe);
        else passed++;
      end
      if (it % 25 == 24 && !mframe) scan_check("rnd_scan", 8);
    end
    if (mframe) send_frame("rnd_abort", 1, {8'h47});
    scan_check("rnd_final", 16);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_invalid();
    test_timeout();
    test_resync();
    test_clear();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
